// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a source holds
  // valid (and its payload) until that edge, and ready never waits on valid.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   b_q, out_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic               neg_q;

  logic               is_div_in, a_signed, b_signed, a_neg, b_neg, neg_in, special_in;
  logic [WIDTH-1:0]   a_mag, b_mag, special_val;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok, calc_exit;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   div_sel, div_s, fix_val;

  // Request decode: operand magnitudes, result sign and the short-circuit divide cases.
  always_comb begin
    is_div_in   = funct3[2];
    a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg       = a_signed & A[WIDTH-1];
    b_neg       = b_signed & B[WIDTH-1];
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    neg_in      = (is_div_in && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    special_in  = 1'b0;
    special_val = '0;
    if (is_div_in && (B == '0)) begin
      special_in  = 1'b1;
      special_val = funct3[1] ? A : ALL1;
    end else if (is_div_in && !funct3[0] && (A == MINV) && (B == ALL1)) begin
      special_in  = 1'b1;
      special_val = funct3[1] ? '0 : MINV;
    end
  end

  // acc_q holds {remainder, dividend/quotient} while dividing, the product while multiplying.
  always_comb begin
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    div_ok    = !div_diff[WIDTH+1];
    prod_s    = neg_q ? -acc_q : acc_q;
    div_sel   = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    div_s     = neg_q ? -div_sel : div_sel;
    if (op_q[2])
      fix_val = div_s;
    else if (op_q == 3'b000)
      fix_val = prod_s[WIDTH-1:0];
    else
      fix_val = prod_s[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
    calc_exit = (cnt_q == CNT_W'(WIDTH-1)) || (!op_q[2] && (b_q[WIDTH-1:1] == '0));
`else
    calc_exit = (cnt_q == CNT_W'(WIDTH-1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (special_in)
            state_d = DONE;
`ifdef MULDIV_EARLY_OUT_EN
          else if (!is_div_in && (b_mag == '0))
            state_d = FIX;
`endif
          else
            state_d = CALC;
        end
      end
      CALC:    if (calc_exit) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= funct3;
            neg_q   <= neg_in;
            cnt_q   <= '0;
            b_q     <= b_mag;
            mcand_q <= {{WIDTH{1'b0}}, a_mag};
            acc_q   <= is_div_in ? {{WIDTH{1'b0}}, a_mag} : '0;
            if (special_in) out_q <= special_val;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_q[2]) begin
            acc_q <= div_ok ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            if (b_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            b_q     <= b_q >> 1;
          end
        end
        FIX:     out_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Out       = out_q;

endmodule
